// File: rtl/band_level_meter.sv
// Per-band visualiser level meter: attack/release envelope, per-frame peak, log2 normalise.
// Optional macro BAND_LEVEL_METER_FALLOFF_EN limits the displayed level to falling 1 LSB per frame.
module band_level_meter #(
  parameter int Q_FP       = 15,
  parameter int DECIM      = 512,
  parameter int ATTACK_SH  = 2,
  parameter int RELEASE_SH = 6
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic signed [31:0] i_data,
  input  logic               i_clear,
  output logic [7:0]         o_level,
  output logic               o_level_valid,
  output logic               o_overrun
);

  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  if (DECIM < 1 || Q_FP < 0) begin : g_param_check
    $error("band_level_meter: DECIM must be >= 1 and Q_FP non-negative");
  end

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_OUT} state_t;

  state_t             state;
  logic [31:0]        env;
  logic [31:0]        peak;
  logic [31:0]        snap;
  logic [4:0]         sh;
  logic [CNT_W-1:0]   count;
  logic [31:0]        mag;
  logic [31:0]        env_next;
  logic [31:0]        peak_max;
  logic               last;
  logic               frame_end;
  logic [7:0]         new_level;

  // Magnitude with the single unrepresentable negative value clamped.
  function automatic logic [31:0] abs_sat(input logic signed [31:0] x);
    logic [31:0] neg;
    neg = 32'(-x);
    if (x == 32'sh8000_0000) return 32'h7FFF_FFFF;
    else if (x < 0)          return neg;
    else                     return 32'(x);
  endfunction

  function automatic logic [31:0] step_min1(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

`ifdef BAND_LEVEL_METER_FALLOFF_EN
  function automatic logic [7:0] falloff(input logic [7:0] nl, input logic [7:0] cur);
    logic [7:0] dec;
    dec = (cur == 8'd0) ? 8'd0 : cur - 8'd1;
    return (nl > dec) ? nl : dec;
  endfunction
`endif

  always_comb begin
    mag      = abs_sat(i_data);
    env_next = env;
    if (mag > env)
      env_next = env + step_min1((mag - env) >> ATTACK_SH);
    else if (mag < env)
      env_next = env - step_min1((env - mag) >> RELEASE_SH);
    peak_max  = (env_next > peak) ? env_next : peak;
    last      = (count == CNT_W'(DECIM - 1));
    frame_end = i_valid && !i_clear && last;
    new_level = (snap == 32'd0) ? 8'd0 : {~sh, snap[30:28]};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      env           <= '0;
      peak          <= '0;
      count         <= '0;
      snap          <= '0;
      sh            <= '0;
      state         <= S_IDLE;
      o_level       <= '0;
      o_level_valid <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      // Envelope / peak / frame counter stage: runs regardless of FSM state.
      if (i_clear) begin
        env   <= '0;
        peak  <= '0;
        count <= '0;
      end else if (i_valid) begin
        env   <= env_next;
        count <= last ? '0 : count + CNT_W'(1);
        peak  <= last ? '0 : peak_max;
      end

      // Normalise stage: shift the frame peak until its MSB is set.
      o_level_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (frame_end) begin
            snap  <= peak_max;
            sh    <= '0;
            state <= S_NORM;
          end
        end
        S_NORM: begin
          if (snap == 32'd0 || snap[31]) begin
`ifdef BAND_LEVEL_METER_FALLOFF_EN
            o_level <= falloff(new_level, o_level);
`else
            o_level <= new_level;
`endif
            o_level_valid <= 1'b1;
            state         <= S_OUT;
          end else begin
            snap <= snap << 1;
            sh   <= sh + 5'd1;
          end
        end
        S_OUT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (frame_end && state != S_IDLE)
        o_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_band_level_meter.sv
// Directed bench for band_level_meter: DECIM=4 frame table plus DECIM=1 corner sequences.
module tb_band_level_meter;

  logic               clk = 1'b0;
  logic               rst;
  logic               valid_a, clear_a, valid_b, clear_b;
  logic signed [31:0] data_a, data_b;
  logic [7:0]         level_a, level_b;
  logic               lv_a, lv_b, ovr_a, ovr_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  band_level_meter #(.Q_FP(15), .DECIM(4), .ATTACK_SH(0), .RELEASE_SH(6)) u_a (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_a), .i_data(data_a), .i_clear(clear_a),
    .o_level(level_a), .o_level_valid(lv_a), .o_overrun(ovr_a)
  );

  band_level_meter #(.Q_FP(15), .DECIM(1), .ATTACK_SH(0), .RELEASE_SH(6)) u_b (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_b), .i_data(data_b), .i_clear(clear_b),
    .o_level(level_b), .o_level_valid(lv_b), .o_overrun(ovr_b)
  );

  typedef struct {
    logic [31:0] data;
    logic [7:0]  lvl;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected displayed level given a freshly normalised level and the previous display.
  function automatic logic [7:0] disp(input logic [7:0] nl, input logic [7:0] prev);
`ifdef BAND_LEVEL_METER_FALLOFF_EN
    logic [7:0] d;
    d = (prev == 8'd0) ? 8'd0 : prev - 8'd1;
    return (nl > d) ? nl : d;
`else
    return (prev === 8'hxx) ? 8'hxx : nl;
`endif
  endfunction

  // Wait for a pulse on u_b; returns cycles counted from the last sample's valid cycle.
  task automatic wait_b(output int lat);
    lat = 1;
    while (lat < 60 && !lv_b) begin
      tick();
      lat++;
    end
  endtask

  task automatic frame_a(input logic [31:0] d, output int lat);
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_a = 1'b1;
      data_a  = d;
      tick();
    end
    valid_a = 1'b0;
    data_a  = '0;
    lat = 1;
    while (lat < 60 && !lv_a) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    logic [7:0] prev_a, prev_b, exp_l;
    int lat, pulses;

    vecs[0]  = '{32'h0000_0000, 8'h00, 2};
    vecs[1]  = '{32'h0000_8000, 8'h78, 18};
    vecs[2]  = '{32'h0000_0000, 8'h00, 2};
    vecs[3]  = '{32'hFFFF_8000, 8'h78, 18};
    vecs[4]  = '{32'h8000_0000, 8'hF7, 3};
    vecs[5]  = '{32'h7FFF_FFFF, 8'hF7, 3};
    vecs[6]  = '{32'h8000_0001, 8'hF7, 3};
    vecs[7]  = '{32'hC000_0000, 8'hF0, 3};
    vecs[8]  = '{32'h1234_5678, 8'hE1, 5};
    vecs[9]  = '{32'h0000_B000, 8'h7B, 18};
    vecs[10] = '{32'h0000_0001, 8'h00, 33};
    vecs[11] = '{32'hFFFF_FFFF, 8'h00, 33};

    rst = 1'b1;
    valid_a = 1'b0; clear_a = 1'b0; data_a = '0;
    valid_b = 1'b0; clear_b = 1'b0; data_b = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("reset_level", {24'd0, level_a}, 32'h00);
    check("reset_valid", {31'd0, lv_a}, 32'h0);
    check("reset_overrun", {31'd0, ovr_a}, 32'h0);
    check("reset_overrun_b", {31'd0, ovr_b}, 32'h0);

    prev_a = 8'h00;
    for (int i = 0; i < 12; i++) begin
      frame_a(vecs[i].data, lat);
      exp_l = disp(vecs[i].lvl, prev_a);
      check($sformatf("vec%0d_level", i), {24'd0, level_a}, {24'd0, exp_l});
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      prev_a = exp_l;
      tick();
      check($sformatf("vec%0d_pulse_width", i), {31'd0, lv_a}, 32'h0);
    end
    check("a_no_overrun", {31'd0, ovr_a}, 32'h0);

    // Release step: 0x8000 then 0 with RELEASE_SH=6 gives env 0x7E00.
    prev_b = 8'h00;
    clear_b = 1'b1; tick(); clear_b = 1'b0;
    valid_b = 1'b1; data_b = 32'sh0000_8000; tick(); valid_b = 1'b0;
    wait_b(lat);
    exp_l = disp(8'h78, prev_b); prev_b = exp_l;
    check("release_first_level", {24'd0, level_b}, {24'd0, exp_l});
    repeat (3) tick();
    valid_b = 1'b1; data_b = '0; tick(); valid_b = 1'b0;
    wait_b(lat);
    exp_l = disp(8'h77, prev_b); prev_b = exp_l;
    check("release_second_level", {24'd0, level_b}, {24'd0, exp_l});
    check("release_latency", lat, 19);
    check("release_no_overrun", {31'd0, ovr_b}, 32'h0);
    repeat (3) tick();

    // Clear with a coincident sample: sample dropped, envelope zeroed.
    clear_b = 1'b1; valid_b = 1'b1; data_b = 32'sh7FFF_FFFF; tick();
    clear_b = 1'b0; valid_b = 1'b0; data_b = '0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (lv_b) pulses++;
      tick();
    end
    check("clear_drops_sample", pulses, 0);
    valid_b = 1'b1; data_b = '0; tick(); valid_b = 1'b0;
    wait_b(lat);
    exp_l = disp(8'h00, prev_b); prev_b = exp_l;
    check("clear_env_zero_level", {24'd0, level_b}, {24'd0, exp_l});
    check("clear_env_zero_latency", lat, 2);
    repeat (3) tick();

    // Back-to-back frames with DECIM=1 overrun the normaliser.
    valid_b = 1'b1; data_b = 32'sh0000_1000;
    tick();
    check("overrun_after_first", {31'd0, ovr_b}, 32'h0);
    tick();
    check("overrun_after_second", {31'd0, ovr_b}, 32'h1);
    repeat (5) tick();
    valid_b = 1'b0;
    repeat (40) tick();
    check("overrun_sticky", {31'd0, ovr_b}, 32'h1);
    clear_b = 1'b1; tick(); clear_b = 1'b0;
    check("overrun_survives_clear", {31'd0, ovr_b}, 32'h1);

    // Reset during a long normalise aborts it without a pulse.
    clear_a = 1'b1; tick(); clear_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_a = 1'b1; data_a = 32'sh0000_0001; tick();
    end
    valid_a = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (lv_a) pulses++;
      tick();
    end
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (lv_a) pulses++;
      tick();
    end
    check("reset_abort_no_pulse", pulses, 0);
    check("reset_abort_level", {24'd0, level_a}, 32'h00);
    check("reset_clears_overrun", {31'd0, ovr_b}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
